phaser_out_core: RTL and testbench
==================================

# phaser_out_core

Cycle-level model of an output-side clock phaser for a memory PHY byte lane. It derives a fast output clock (OCLK), a tap-delayed copy (OCLKDELAYED) and a divided clock (OCLKDIV) from reference clocks. It exposes fine/coarse tap adjustment, a 9-bit tap load/readback counter, overflow flags and an OSERDES reset pulse. It sits between the clocking network and the lane's OSERDES blocks; all state is clocked by FREQREFCLK, and delays are counted in FREQREFCLK cycles.

## Interface
- CLKOUT_DIV, 4'b0010, divide code; divide ratio N = code+2 (codes 0..14 give 2..16; code 15 is treated as 14).
- CLKOUT_DIV_POS, 4'b0010, number of high cycles of OCLKDIV per period; a value of 0 or a value ≥N is replaced by floor(N/2).
- COARSE_BYPASS, 1'b0, when 1 the coarse tap contributes 0 delay.
- COARSE_DELAY, 6'd0, coarse tap reset/RST value.
- FINE_DELAY, 6'd0, fine tap reset/RST value.
- OCLK_DELAY, 6'd0, base delay of OCLKDELAYED in cycles.
- OCLKDELAY_INV, 1'b0, inverts OCLKDELAYED.
- OUTPUT_CLK_SRC, 2'b00, OCLK source: 00 PHASEREFCLK, 10 FREQREFCLK, 01 and 11 delayed PHASEREFCLK.
- EN_OSERDES_RST, 1'b0, enables OSERDESRST generation.
- SYNC_IN_DIV_RST, 1'b0, when 1 a SYNCIN rising edge restarts the divider.
- Reset is DIVIDERST, asynchronous, active-low; the clock is FREQREFCLK.
- FREQREFCLK in 1: reference clock; all registers update on its rising edge.
- DIVIDERST in 1: asynchronous active-low reset.
- RST in 1: synchronous active-high tap reset.
- PHASEREFCLK in 1: phase reference, sampled each cycle.
- SYNCIN in 1: divider sync, sampled; a rising edge is detected between two samples.
- FINEENABLE, FINEINC in 1: fine tap step enable and direction (1 = up).
- COARSEENABLE, COARSEINC in 1: coarse tap step enable and direction.
- COUNTERLOADEN in 1, COUNTERLOADVAL in 9: tap load.
- COUNTERREADEN in 1: capture taps into COUNTERREADVAL.
- EDGEADV in 1: advance OCLKDIV phase by one cycle.
- SELFINEOCLKDELAY in 1: adds the fine tap to the OCLKDELAYED delay.
- SYSCLK, MEMREFCLK in 1: present for pin compatibility; unused.
- OCLK out 1; OCLKDELAYED out 1; OCLKDIV out 1; OSERDESRST out 1.
- FINEOVERFLOW, COARSEOVERFLOW out 1; COUNTERREADVAL out 9.

## Operation
- Sampling: ph_hist is a 128-bit shift register; bit 0 receives PHASEREFCLK every cycle.
- Delayed source: D = fine_tap + (COARSE_BYPASS ? 0 : coarse_tap), range 0..126; dly = ph_hist[D].
- OCLK is combinational: PHASEREFCLK or FREQREFCLK passthrough per OUTPUT_CLK_SRC, or dly for codes 01/11.
- OCLKDELAYED is registered: ph_hist[OCLK_DELAY + (SELFINEOCLKDELAY ? fine_tap : 0)] XOR OCLKDELAY_INV.
- Tap update priority, evaluated each cycle: RST, then COUNTERLOADEN, then FINEENABLE/COARSEENABLE. Fine and coarse enables act independently in the same cycle.
- RST: fine_tap = FINE_DELAY, coarse_tap = COARSE_DELAY, both overflow flags cleared.
- Load: fine_tap = VAL[5:0], coarse_tap = {3'b000, VAL[8:6]}; overflow flags cleared.
- Step: each cycle an enable is high, the tap moves ±1. Incrementing at 63 or decrementing at 0 leaves the tap unchanged (saturate) and sets that tap's overflow flag. Any successful step clears that tap's overflow flag.
- Read: when COUNTERREADEN is high, COUNTERREADVAL <= {coarse_tap[2:0], fine_tap} using pre-update tap values. Otherwise COUNTERREADVAL holds.
- Divider: cnt counts 0..N-1 and wraps; OCLKDIV is registered as (next cnt < POS).
- EDGEADV: cnt advances by 2 (mod N) instead of 1 for that cycle.
- SYNCIN rising edge with SYNC_IN_DIV_RST=1: cnt is forced to 0; this overrides EDGEADV.
- OSERDESRST: when EN_OSERDES_RST=1, it is 1 from reset until the first OCLKDIV rising edge after DIVIDERST release, then 0. It is 0 whenever EN_OSERDES_RST=0.

## Timing
- Values while DIVIDERST is low: ph_hist=0, taps at parameter values, cnt=0, OCLKDIV=0, overflow flags 0, COUNTERREADVAL=0, OCLKDELAYED=OCLKDELAY_INV, OSERDESRST=EN_OSERDES_RST.
- Latency of one cycle for: tap step/load/RST to the new tap value; READEN to COUNTERREADVAL; an overflow attempt to the flag.
- The new tap value affects dly in the cycle after it is registered.
- dly latency equals D+1 cycles from PHASEREFCLK to OCLK.
- After release, OCLKDIV rises on the first edge where the next cnt is 0, i.e. 1 cycle after release. OSERDESRST falls on that same edge.
- Reset mid-operation clears the divider immediately; the next period starts clean.

## Test plan
- Reset/defaults: DIVIDERST low, then high with CLKOUT_DIV=2 (N=4), POS=2 -> OCLKDIV pattern 1100 repeating, OSERDESRST=0, COUNTERREADVAL=0.
- Fine stepping: FINE_DELAY=62, three FINEENABLE+FINEINC cycles -> fine_tap 63, 63, 63; FINEOVERFLOW=1 after the 2nd step. One decrement -> 62, FINEOVERFLOW=0.
- Load/read: COUNTERLOADVAL=9'h15A, then READEN -> COUNTERREADVAL=9'h15A (coarse 5, fine 26). Coarse decrement from 0 -> COARSEOVERFLOW=1.
- Delay path: OUTPUT_CLK_SRC=01, fine=3, coarse=2, PHASEREFCLK single-cycle pulse -> OCLK pulse 6 cycles later. With COARSE_BYPASS=1 -> 4 cycles later.
- Divider control: N=4; EDGEADV pulse -> one OCLKDIV period shortened to 3 cycles. SYNC_IN_DIV_RST=1 and SYNCIN rising -> cnt restarts at 0, OCLKDIV high the next cycle.
- OSERDES reset: EN_OSERDES_RST=1 -> OSERDESRST=1 during reset, falls together with the first OCLKDIV rise. OCLKDELAY_INV=1, OCLK_DELAY=2 -> OCLKDELAYED is the inverted PHASEREFCLK, 3 cycles late.

Source files
------------

// File: rtl/phaser_out_core.sv
// -----------------------------------------------------------------------------
// phaser_out_core
// Cycle-level output phaser for one memory PHY byte lane. It derives a fast
// output clock (OCLK), a tap-delayed copy (OCLKDELAYED) and a divided clock
// (OCLKDIV), and provides fine/coarse tap stepping, a 9-bit tap load/readback
// counter, overflow flags and an OSERDES reset pulse. Every register is
// clocked by FREQREFCLK, and all delays are counted in FREQREFCLK cycles.
//
// Ports
//   FREQREFCLK        in   reference clock (rising edge)
//   DIVIDERST         in   asynchronous active-low reset
//   RST               in   synchronous tap reset to FINE_DELAY/COARSE_DELAY
//   PHASEREFCLK       in   phase reference, sampled every cycle
//   SYNCIN            in   divider sync; a rising edge restarts the divider
//   FINEENABLE/INC    in   fine tap step enable / direction (1 = up)
//   COARSEENABLE/INC  in   coarse tap step enable / direction (1 = up)
//   COUNTERLOADEN/VAL in   tap load {coarse[2:0], fine[5:0]}
//   COUNTERREADEN     in   capture the taps into COUNTERREADVAL
//   EDGEADV           in   advance the OCLKDIV phase by one cycle
//   SELFINEOCLKDELAY  in   add the fine tap to the OCLKDELAYED delay
//   SYSCLK, MEMREFCLK in   pin compatibility only
//   OCLK              out  selected output clock (combinational)
//   OCLKDELAYED       out  delayed, optionally inverted PHASEREFCLK
//   OCLKDIV           out  divided clock
//   OSERDESRST        out  OSERDES reset, released on the first OCLKDIV rise
//   FINEOVERFLOW      out  fine tap saturated on its last step attempt
//   COARSEOVERFLOW    out  coarse tap saturated on its last step attempt
//   COUNTERREADVAL    out  captured tap values
// -----------------------------------------------------------------------------
module phaser_out_core #(
   parameter logic [3:0] CLKOUT_DIV      = 4'b0010,
   parameter logic [3:0] CLKOUT_DIV_POS  = 4'b0010,
   parameter logic       COARSE_BYPASS   = 1'b0,
   parameter logic [5:0] COARSE_DELAY    = 6'd0,
   parameter logic [5:0] FINE_DELAY      = 6'd0,
   parameter logic [5:0] OCLK_DELAY      = 6'd0,
   parameter logic       OCLKDELAY_INV   = 1'b0,
   parameter logic [1:0] OUTPUT_CLK_SRC  = 2'b00,
   parameter logic       EN_OSERDES_RST  = 1'b0,
   parameter logic       SYNC_IN_DIV_RST = 1'b0
) (
   input  logic       FREQREFCLK,
   input  logic       DIVIDERST,
   input  logic       RST,
   input  logic       PHASEREFCLK,
   input  logic       SYNCIN,
   input  logic       FINEENABLE,
   input  logic       FINEINC,
   input  logic       COARSEENABLE,
   input  logic       COARSEINC,
   input  logic       COUNTERLOADEN,
   input  logic [8:0] COUNTERLOADVAL,
   input  logic       COUNTERREADEN,
   input  logic       EDGEADV,
   input  logic       SELFINEOCLKDELAY,
   input  logic       SYSCLK,
   input  logic       MEMREFCLK,
   output logic       OCLK,
   output logic       OCLKDELAYED,
   output logic       OCLKDIV,
   output logic       OSERDESRST,
   output logic       FINEOVERFLOW,
   output logic       COARSEOVERFLOW,
   output logic [8:0] COUNTERREADVAL
);

   // Code 15 folds onto 14; an out-of-range high time becomes a half period.
   localparam int N_I   = ((CLKOUT_DIV == 4'd15) ? 14 : int'(CLKOUT_DIV)) + 2;
   localparam int POS_I = ((CLKOUT_DIV_POS == 4'd0) || (int'(CLKOUT_DIV_POS) >= N_I))
                          ? (N_I / 2) : int'(CLKOUT_DIV_POS);
   localparam logic [4:0] N_V   = 5'(N_I);
   localparam logic [4:0] POS_V = 5'(POS_I);

   logic [127:0] r_ph_hist;
   logic [5:0]   r_fine, r_coarse;
   logic         r_fine_ovf, r_coarse_ovf;
   logic [8:0]   r_read_val;
   logic [4:0]   r_cnt;
   logic         r_run;
   logic         r_oclkdiv, r_oclkdly, r_oserdes_rst, r_syncin_q;

   logic [127:0] w_hist_next;
   logic [6:0]   w_dly_idx, w_odly_idx;
   logic         w_dly;
   logic [5:0]   w_fine_next, w_coarse_next;
   logic         w_fine_ovf_next, w_coarse_ovf_next;
   logic         w_sync_rise;
   logic [4:0]   w_cnt_p1, w_cnt_p2, w_cnt_next;
   logic         w_div_next;
   logic         w_unused;

   assign w_unused    = SYSCLK ^ MEMREFCLK;
   assign w_hist_next = {r_ph_hist[126:0], PHASEREFCLK};

   // Tap delay into the sampled history; bit D holds PHASEREFCLK from D+1 edges ago.
   assign w_dly_idx  = {1'b0, r_fine} + (COARSE_BYPASS ? 7'd0 : {1'b0, r_coarse});
   assign w_dly      = r_ph_hist[w_dly_idx];

   // OCLKDELAYED samples the post-shift history so its latency is also index+1.
   assign w_odly_idx = {1'b0, OCLK_DELAY} + (SELFINEOCLKDELAY ? {1'b0, r_fine} : 7'd0);

   always_comb begin
      case (OUTPUT_CLK_SRC)
         2'b00:   OCLK = PHASEREFCLK;
         2'b10:   OCLK = FREQREFCLK;
         default: OCLK = w_dly;
      endcase
   end

   // Tap update: RST beats load beats stepping; fine and coarse step independently.
   always_comb begin
      w_fine_next       = r_fine;
      w_coarse_next     = r_coarse;
      w_fine_ovf_next   = r_fine_ovf;
      w_coarse_ovf_next = r_coarse_ovf;
      if (RST) begin
         w_fine_next       = FINE_DELAY;
         w_coarse_next     = COARSE_DELAY;
         w_fine_ovf_next   = 1'b0;
         w_coarse_ovf_next = 1'b0;
      end else if (COUNTERLOADEN) begin
         w_fine_next       = COUNTERLOADVAL[5:0];
         w_coarse_next     = {3'b000, COUNTERLOADVAL[8:6]};
         w_fine_ovf_next   = 1'b0;
         w_coarse_ovf_next = 1'b0;
      end else begin
         if (FINEENABLE) begin
            if (FINEINC ? (r_fine == 6'd63) : (r_fine == 6'd0)) begin
               w_fine_ovf_next = 1'b1;
            end else begin
               w_fine_next     = FINEINC ? (r_fine + 6'd1) : (r_fine - 6'd1);
               w_fine_ovf_next = 1'b0;
            end
         end
         if (COARSEENABLE) begin
            if (COARSEINC ? (r_coarse == 6'd63) : (r_coarse == 6'd0)) begin
               w_coarse_ovf_next = 1'b1;
            end else begin
               w_coarse_next     = COARSEINC ? (r_coarse + 6'd1) : (r_coarse - 6'd1);
               w_coarse_ovf_next = 1'b0;
            end
         end
      end
   end

   // Divider. The first edge after reset release holds cnt at 0 so that the
   // first OCLKDIV period begins on that edge.
   assign w_sync_rise = SYNCIN & ~r_syncin_q;
   assign w_cnt_p1    = (r_cnt == (N_V - 5'd1)) ? 5'd0 : (r_cnt + 5'd1);
   assign w_cnt_p2    = ((r_cnt + 5'd2) >= N_V) ? (r_cnt + 5'd2 - N_V) : (r_cnt + 5'd2);

   always_comb begin
      if (!r_run)
         w_cnt_next = 5'd0;
      else if (SYNC_IN_DIV_RST && w_sync_rise)
         w_cnt_next = 5'd0;
      else if (EDGEADV)
         w_cnt_next = w_cnt_p2;
      else
         w_cnt_next = w_cnt_p1;
   end

   assign w_div_next = (w_cnt_next < POS_V);

   always_ff @(posedge FREQREFCLK or negedge DIVIDERST) begin
      if (!DIVIDERST) begin
         r_ph_hist     <= '0;
         r_fine        <= FINE_DELAY;
         r_coarse      <= COARSE_DELAY;
         r_fine_ovf    <= 1'b0;
         r_coarse_ovf  <= 1'b0;
         r_read_val    <= 9'd0;
         r_cnt         <= 5'd0;
         r_run         <= 1'b0;
         r_oclkdiv     <= 1'b0;
         r_oclkdly     <= OCLKDELAY_INV;
         r_oserdes_rst <= EN_OSERDES_RST;
         r_syncin_q    <= 1'b0;
      end else begin
         r_ph_hist     <= w_hist_next;
         r_oclkdly     <= w_hist_next[w_odly_idx] ^ OCLKDELAY_INV;
         r_fine        <= w_fine_next;
         r_coarse      <= w_coarse_next;
         r_fine_ovf    <= w_fine_ovf_next;
         r_coarse_ovf  <= w_coarse_ovf_next;
         if (COUNTERREADEN)
            r_read_val <= {r_coarse[2:0], r_fine};
         r_cnt         <= w_cnt_next;
         r_run         <= 1'b1;
         r_oclkdiv     <= w_div_next;
         r_syncin_q    <= SYNCIN;
         // Released on the first rising edge of OCLKDIV; never set again until reset.
         if (w_div_next && !r_oclkdiv)
            r_oserdes_rst <= 1'b0;
      end
   end

   assign OCLKDELAYED    = r_oclkdly;
   assign OCLKDIV        = r_oclkdiv;
   assign OSERDESRST     = r_oserdes_rst;
   assign FINEOVERFLOW   = r_fine_ovf;
   assign COARSEOVERFLOW = r_coarse_ovf;
   assign COUNTERREADVAL = r_read_val;

endmodule

// File: tb/tb_phaser_out_core.sv
// -----------------------------------------------------------------------------
// tb_phaser_out_core
// Two phaser instances with different parameter sets share one stimulus
// stream. A behavioural model (PHASEREFCLK log indexed by edge number, integer
// taps, divider phase) predicts every output after every edge; directed
// sequences add literal expectations, then a randomized run with a mid-run
// reset follows.
// -----------------------------------------------------------------------------
module tb_phaser_out_core;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       divrst, rst, phref, syncin, fen, finc, cen, cinc, lden, rden, edgeadv, selfine;
   logic [8:0] ldval;
   logic [1:0] oclk, odly, odiv, osr, fovf, covf;
   logic [8:0] rv [2];

   int errors = 0;
   int checks = 0;

   // Instance parameters, with derived N / POS worked out by hand.
   int P_N   [2] = '{4, 7};
   int P_POS [2] = '{2, 3};
   int P_BYP [2] = '{0, 1};
   int P_CD  [2] = '{0, 2};
   int P_FD  [2] = '{62, 3};
   int P_OD  [2] = '{2, 5};
   int P_INV [2] = '{1, 0};
   int P_EN  [2] = '{1, 0};
   int P_SYNC[2] = '{1, 0};

   phaser_out_core #(
      .CLKOUT_DIV(4'd2), .CLKOUT_DIV_POS(4'd2), .COARSE_BYPASS(1'b0), .COARSE_DELAY(6'd0),
      .FINE_DELAY(6'd62), .OCLK_DELAY(6'd2), .OCLKDELAY_INV(1'b1), .OUTPUT_CLK_SRC(2'b01),
      .EN_OSERDES_RST(1'b1), .SYNC_IN_DIV_RST(1'b1)
   ) u_a (
      .FREQREFCLK(clk), .DIVIDERST(divrst), .RST(rst), .PHASEREFCLK(phref), .SYNCIN(syncin),
      .FINEENABLE(fen), .FINEINC(finc), .COARSEENABLE(cen), .COARSEINC(cinc),
      .COUNTERLOADEN(lden), .COUNTERLOADVAL(ldval), .COUNTERREADEN(rden), .EDGEADV(edgeadv),
      .SELFINEOCLKDELAY(selfine), .SYSCLK(clk), .MEMREFCLK(clk),
      .OCLK(oclk[0]), .OCLKDELAYED(odly[0]), .OCLKDIV(odiv[0]), .OSERDESRST(osr[0]),
      .FINEOVERFLOW(fovf[0]), .COARSEOVERFLOW(covf[0]), .COUNTERREADVAL(rv[0])
   );

   phaser_out_core #(
      .CLKOUT_DIV(4'd5), .CLKOUT_DIV_POS(4'd0), .COARSE_BYPASS(1'b1), .COARSE_DELAY(6'd2),
      .FINE_DELAY(6'd3), .OCLK_DELAY(6'd5), .OCLKDELAY_INV(1'b0), .OUTPUT_CLK_SRC(2'b11),
      .EN_OSERDES_RST(1'b0), .SYNC_IN_DIV_RST(1'b0)
   ) u_b (
      .FREQREFCLK(clk), .DIVIDERST(divrst), .RST(rst), .PHASEREFCLK(phref), .SYNCIN(syncin),
      .FINEENABLE(fen), .FINEINC(finc), .COARSEENABLE(cen), .COARSEINC(cinc),
      .COUNTERLOADEN(lden), .COUNTERLOADVAL(ldval), .COUNTERREADEN(rden), .EDGEADV(edgeadv),
      .SELFINEOCLKDELAY(selfine), .SYSCLK(clk), .MEMREFCLK(clk),
      .OCLK(oclk[1]), .OCLKDELAYED(odly[1]), .OCLKDIV(odiv[1]), .OSERDESRST(osr[1]),
      .FINEOVERFLOW(fovf[1]), .COARSEOVERFLOW(covf[1]), .COUNTERREADVAL(rv[1])
   );

   // ---------------- behavioural model ----------------
   int ne;                 // edges since reset release
   bit plog [0:4095];      // PHASEREFCLK sampled at edge k
   bit m_sprev;
   int m_fine[2], m_coarse[2], m_fovf[2], m_covf[2], m_rv[2], m_p[2], m_div[2], m_osr[2], m_odly[2];

   function automatic bit hist(int k);
      return (k >= 1) ? plog[k] : 1'b0;
   endfunction

   task automatic model_reset();
      ne = 0;
      m_sprev = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_fine[i] = P_FD[i];  m_coarse[i] = P_CD[i];
         m_fovf[i] = 0;        m_covf[i] = 0;
         m_rv[i] = 0;          m_p[i] = 0;  m_div[i] = 0;
         m_osr[i] = P_EN[i];   m_odly[i] = P_INV[i];
      end
   endtask

   task automatic step_tap(inout int t, inout int f, input bit inc);
      if (inc) begin
         if (t == 63) f = 1; else begin t = t + 1; f = 0; end
      end else begin
         if (t == 0) f = 1; else begin t = t - 1; f = 0; end
      end
   endtask

   task automatic model_step();
      bit rise;
      int nd;
      if (!divrst) return;
      ne = ne + 1;
      plog[ne] = phref;
      rise = syncin && !m_sprev;
      for (int i = 0; i < 2; i++) begin
         m_odly[i] = hist(ne - (P_OD[i] + (selfine ? m_fine[i] : 0))) ^ P_INV[i];
         if (rden) m_rv[i] = (m_coarse[i] % 8) * 64 + m_fine[i];
         if (rst) begin
            m_fine[i] = P_FD[i]; m_coarse[i] = P_CD[i]; m_fovf[i] = 0; m_covf[i] = 0;
         end else if (lden) begin
            m_fine[i] = ldval % 64; m_coarse[i] = ldval / 64; m_fovf[i] = 0; m_covf[i] = 0;
         end else begin
            if (fen) step_tap(m_fine[i], m_fovf[i], finc);
            if (cen) step_tap(m_coarse[i], m_covf[i], cinc);
         end
         if (ne == 1) m_p[i] = 0;
         else if (rise && P_SYNC[i] != 0) m_p[i] = 0;
         else m_p[i] = (m_p[i] + (edgeadv ? 2 : 1)) % P_N[i];
         nd = (m_p[i] < P_POS[i]) ? 1 : 0;
         if (P_EN[i] != 0 && nd == 1 && m_div[i] == 0) m_osr[i] = 0;
         m_div[i] = nd;
      end
      m_sprev = syncin;
   endtask

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", name, i, $time, act, exp);
      end
   endtask

   task automatic check_cycle();
      for (int i = 0; i < 2; i++) begin
         chk("oclk", i, 32'(oclk[i]), 32'(hist(ne - (m_fine[i] + (P_BYP[i] != 0 ? 0 : m_coarse[i])))));
         chk("oclkdelayed", i, 32'(odly[i]), 32'(m_odly[i]));
         chk("oclkdiv", i, 32'(odiv[i]), 32'(m_div[i]));
         chk("oserdesrst", i, 32'(osr[i]), 32'(m_osr[i]));
         chk("fineovf", i, 32'(fovf[i]), 32'(m_fovf[i]));
         chk("coarseovf", i, 32'(covf[i]), 32'(m_covf[i]));
         chk("readval", i, 32'(rv[i]), 32'(m_rv[i]));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_cycle();
      $display("cyc ne=%0d rst_n=%0b ph=%0b div=%b osr=%b rv=%h/%h", ne, divrst, phref, odiv, osr, rv[0], rv[1]);
   endtask

   task automatic idle();
      rst = 0; phref = 0; syncin = 0; fen = 0; finc = 0; cen = 0; cinc = 0;
      lden = 0; ldval = 9'd0; rden = 0; edgeadv = 0; selfine = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] pat;
      logic [4:0] spat;
      int lat_oa, lat_ob, lat_da, lat_db;

      idle();
      divrst = 1'b0;
      model_reset();
      repeat (3) tick();
      chk("rst_osr_lit", 0, 32'(osr[0]), 32'd1);
      chk("rst_osr_lit", 1, 32'(osr[1]), 32'd0);
      chk("rst_odly_lit", 0, 32'(odly[0]), 32'd1);
      chk("rst_rv_lit", 0, 32'(rv[0]), 32'd0);

      // Release: A runs N=4, POS=2 -> 1100 repeating from the first edge.
      divrst = 1'b1;
      pat = 8'd0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) chk("osr_fall_lit", 0, 32'({osr[0], odiv[0]}), 32'b01);
         pat = {pat[6:0], odiv[0]};
      end
      chk("div_pattern_lit", 0, 32'(pat), 32'b11001100);

      // Fine stepping from 62 on A.
      fen = 1; finc = 1;
      tick(); chk("fovf_step1_lit", 0, 32'(fovf[0]), 32'd0);
      tick(); chk("fovf_step2_lit", 0, 32'(fovf[0]), 32'd1);
      tick();
      fen = 0; rden = 1;
      tick(); chk("fine63_lit", 0, 32'(rv[0]), 32'd63);
      rden = 0; fen = 1; finc = 0;
      tick(); chk("fovf_dec_lit", 0, 32'(fovf[0]), 32'd0);
      fen = 0; rden = 1;
      tick(); chk("fine62_lit", 0, 32'(rv[0]), 32'd62);

      // Load / readback, then coarse underflow.
      rden = 0; lden = 1; ldval = 9'h15A;
      tick();
      lden = 0; rden = 1;
      tick();
      chk("load_read_lit", 0, 32'(rv[0]), 32'h15A);
      chk("load_read_lit", 1, 32'(rv[1]), 32'h15A);
      rden = 0; lden = 1; ldval = 9'h000;
      tick();
      lden = 0; cen = 1; cinc = 0;
      tick();
      chk("covf_lit", 0, 32'(covf[0]), 32'd1);
      chk("covf_lit", 1, 32'(covf[1]), 32'd1);

      // Delay path: fine 3, coarse 2.
      cen = 0; lden = 1; ldval = {3'd2, 6'd3};
      tick();
      lden = 0;
      repeat (10) tick();
      lat_oa = 0; lat_ob = 0; lat_da = 0; lat_db = 0;
      for (int c = 0; c < 12; c++) begin
         phref = (c == 0);
         tick();
         if (oclk[0] && lat_oa == 0) lat_oa = c + 1;
         if (oclk[1] && lat_ob == 0) lat_ob = c + 1;
         if (!odly[0] && lat_da == 0) lat_da = c + 1;
         if (odly[1] && lat_db == 0) lat_db = c + 1;
      end
      phref = 0;
      chk("oclk_lat_lit", 0, 32'(lat_oa), 32'd6);
      chk("oclk_lat_lit", 1, 32'(lat_ob), 32'd4);
      chk("odly_lat_lit", 0, 32'(lat_da), 32'd3);
      chk("odly_lat_lit", 1, 32'(lat_db), 32'd6);

      // SYNCIN restart followed by an EDGEADV on A: 1,1,(adv)0,1,1.
      syncin = 1;
      tick(); spat = {4'd0, odiv[0]};
      chk("sync_div_lit", 0, 32'(odiv[0]), 32'd1);
      syncin = 0;
      tick(); spat = {spat[3:0], odiv[0]};
      edgeadv = 1;
      tick(); spat = {spat[3:0], odiv[0]};
      edgeadv = 0;
      tick(); spat = {spat[3:0], odiv[0]};
      tick(); spat = {spat[3:0], odiv[0]};
      chk("edgeadv_pat_lit", 0, 32'(spat), 32'b11011);

      // Randomized run with one asynchronous reset in the middle.
      for (int n = 0; n < 800; n++) begin
         phref   = 1'($urandom_range(0, 1));
         syncin  = ($urandom_range(0, 5) == 0);
         fen     = ($urandom_range(0, 2) == 0);
         finc    = 1'($urandom_range(0, 1));
         cen     = ($urandom_range(0, 2) == 0);
         cinc    = 1'($urandom_range(0, 1));
         rst     = ($urandom_range(0, 40) == 0);
         lden    = ($urandom_range(0, 25) == 0);
         ldval   = 9'($urandom_range(0, 511));
         rden    = 1'($urandom_range(0, 1));
         edgeadv = ($urandom_range(0, 7) == 0);
         selfine = 1'($urandom_range(0, 1));
         tick();
         if (n == 400) begin
            #2;
            divrst = 1'b0;
            #1;
            model_reset();
            check_cycle();
            tick();
            tick();
            divrst = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
